// File: rtl/soc_system_pio_pkg.sv
// rtl/soc_system_pio_pkg.sv - shared constants and types for the pulse-capable output PIO
package soc_system_pio_pkg;

  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] ADDR_PULSE     = 3'd3;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd4;
  localparam logic [2:0] ADDR_STATUS    = 3'd5;
  localparam logic [2:0] ADDR_TSTAMP    = 3'd6;

  localparam int STATUS_BUSY_BIT    = 0;
  localparam int STATUS_OVERRUN_BIT = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_e;

endpackage

// File: rtl/soc_system_pio_pulse_timer.sv
// rtl/soc_system_pio_pulse_timer.sv - pulse FSM with length counter and latched bit mask
module soc_system_pio_pulse_timer
  import soc_system_pio_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] start_mask,
  input  logic [CNT_W-1:0] pulse_len,
  output logic             busy,
  output logic             accept,
  output logic             overrun_set,
  output logic             done,
  output logic [WIDTH-1:0] mask
);

  pulse_state_e     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mask_q, mask_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
    end
  end

  // A length of zero is treated as one cycle, so the counter loads max(len,1)-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    case (state_q)
      IDLE: begin
        if (start && (start_mask != '0)) begin
          state_d = ACTIVE;
          mask_d  = start_mask;
          cnt_d   = (pulse_len == '0) ? '0 : pulse_len - CNT_W'(1);
        end
      end
      ACTIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = IDLE;
          mask_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == ACTIVE);
    accept      = (state_q == IDLE) && start && (start_mask != '0);
    overrun_set = (state_q == ACTIVE) && start;
    done        = (state_q == ACTIVE) && (cnt_q == '0);
    mask        = mask_q;
  end

endmodule

// File: rtl/soc_system_pio_pulse_out.sv
// rtl/soc_system_pio_pulse_out.sv - Avalon-MM output PIO with set/clear, timed pulses
// and an optional write timestamp enabled by PIO_PULSE_OUT_TSTAMP_EN.
module soc_system_pio_pulse_out
  import soc_system_pio_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               CNT_W       = 16,
  parameter int               TS_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             ovr_q, ovr_d;
  logic             wr, wr_pulse;
  logic             busy, accept, overrun_set, done;
  logic [WIDTH-1:0] pulse_mask;
  logic [WIDTH-1:0] wd;
  logic [31:0]      ts_read;
  logic             unused_wd;

  assign wr        = chipselect && !write_n;
  assign wr_pulse  = wr && (address == ADDR_PULSE);
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  soc_system_pio_pulse_timer #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .start      (wr_pulse),
    .start_mask (wd),
    .pulse_len  (len_q),
    .busy       (busy),
    .accept     (accept),
    .overrun_set(overrun_set),
    .done       (done),
    .mask       (pulse_mask)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_VALUE;
      len_q <= CNT_W'(1);
      ovr_q <= 1'b0;
    end else begin
      out_q <= out_d;
      len_q <= len_d;
      ovr_q <= ovr_d;
    end
  end

  // Register writes first, then pulse start, then pulse-end clear so pulse bits always end low.
  always_comb begin
    out_d = out_q;
    len_d = len_q;
    ovr_d = ovr_q;
    if (wr) begin
      case (address)
        ADDR_DATA:      out_d = wd;
        ADDR_SET:       out_d = out_q | wd;
        ADDR_CLEAR:     out_d = out_q & ~wd;
        ADDR_PULSE_LEN: len_d = writedata[CNT_W-1:0];
        ADDR_STATUS:    ovr_d = 1'b0;
        default:        ;
      endcase
    end
    if (accept)      out_d = out_d | wd;
    if (done)        out_d = out_d & ~pulse_mask;
    if (overrun_set) ovr_d = 1'b1;
  end

`ifdef PIO_PULSE_OUT_TSTAMP_EN
  logic [TS_W-1:0] ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0] ts_cap_q, ts_cap_d;
  logic            ts_capture;

  assign ts_capture = accept || (wr && ((address == ADDR_DATA) || (address == ADDR_SET) ||
                                        (address == ADDR_CLEAR)));

  always_ff @(posedge clk) begin
    if (reset) begin
      ts_cnt_q <= '0;
      ts_cap_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      ts_cap_q <= ts_cap_d;
    end
  end

  always_comb begin
    ts_cnt_d = ts_cnt_q + TS_W'(1);
    ts_cap_d = ts_capture ? ts_cnt_q : ts_cap_q;
  end

  assign ts_read = 32'(ts_cap_q);
`else
  localparam int unused_ts_w = TS_W;
  assign ts_read = '0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA, ADDR_SET, ADDR_CLEAR: readdata = 32'(out_q);
      ADDR_PULSE:     readdata = 32'(pulse_mask);
      ADDR_PULSE_LEN: readdata = 32'(len_q);
      ADDR_STATUS: begin
        readdata[STATUS_BUSY_BIT]    = busy;
        readdata[STATUS_OVERRUN_BIT] = ovr_q;
      end
      ADDR_TSTAMP:    readdata = ts_read;
      default:        readdata = '0;
    endcase
  end

  assign out_port = out_q;

endmodule

// File: tb/tb_soc_system_pio_pulse_out.sv
// tb/tb_soc_system_pio_pulse_out.sv - scoreboard bench for soc_system_pio_pulse_out
module tb_soc_system_pio_pulse_out;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          is_out;
    logic [31:0] exp;
    string       tag;
  } chk_t;

  chk_t sb[$];

  soc_system_pio_pulse_out #(
    .WIDTH      (8),
    .RESET_VALUE(8'hA5),
    .CNT_W      (16),
    .TS_W       (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_port  (out_port)
  );

  always #5 clk = ~clk;

  logic [7:0] ts_m;
  always @(posedge clk) begin
    if (reset) ts_m <= 8'h00;
    else       ts_m <= ts_m + 8'h01;
  end

  // Monitor: everything queued during a cycle is compared at that cycle's falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      chk_t c;
      logic [31:0] act;
      c   = sb.pop_front();
      act = c.is_out ? {24'h0, out_port} : readdata;
      n_checks++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got 0x%0h expected 0x%0h", c.tag, act, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_out(input logic [7:0] e, input string t);
    chk_t c;
    c.is_out = 1'b1;
    c.exp    = {24'h0, e};
    c.tag    = t;
    sb.push_back(c);
  endtask

  task automatic exp_rd(input logic [2:0] a, input logic [31:0] e, input string t);
    chk_t c;
    address  = a;
    c.is_out = 1'b0;
    c.exp    = e;
    c.tag    = t;
    sb.push_back(c);
  endtask

  task automatic drive_wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    drive_wr(a, d);
    tick();
    idle();
  endtask

  task automatic wait_ts(input logic [7:0] v);
    for (int i = 0; i < 600 && ts_m != v; i++) tick();
    n_checks++;
    if (ts_m != v) begin
      n_fail++;
      $display("FAIL ts_wait: counter model at 0x%0h expected 0x%0h", ts_m, v);
    end
  endtask

  logic [7:0] ts_cap;

  initial begin
    reset      = 1'b1;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
    repeat (3) tick();
    reset = 1'b0;

    exp_out(8'hA5, "rst_out");
    exp_rd(3'd4, 32'h1, "rst_len");
    tick();
    exp_rd(3'd5, 32'h0, "rst_status");
    tick();

    drive_wr(3'd0, 32'h3C);
    exp_out(8'hA5, "data_pre_edge");
    tick();
    idle();
    exp_out(8'h3C, "data_wr");
    exp_rd(3'd0, 32'h3C, "data_rd");
    tick();

    wr(3'd0, 32'h00);
    wr(3'd1, 32'h81);
    exp_out(8'h81, "set");
    tick();
    wr(3'd2, 32'h01);
    exp_out(8'h80, "clear");
    exp_rd(3'd1, 32'h80, "set_rd");
    tick();
    exp_rd(3'd2, 32'h80, "clear_rd");
    tick();

    wr(3'd4, 32'h5);
    exp_rd(3'd4, 32'h5, "len_rd");
    tick();
    wr(3'd3, 32'h04);
    for (int k = 0; k < 5; k++) begin
      exp_out(8'h84, "pulse5_hi");
      if (k == 0) exp_rd(3'd3, 32'h04, "pulse_mask_rd");
      else        exp_rd(3'd5, 32'h1, "pulse5_busy");
      tick();
    end
    exp_out(8'h80, "pulse5_end");
    exp_rd(3'd5, 32'h0, "pulse5_idle");
    tick();

    wr(3'd4, 32'h0);
    exp_rd(3'd4, 32'h0, "len0_rd");
    tick();
    wr(3'd3, 32'h01);
    exp_out(8'h81, "pulse0_hi");
    exp_rd(3'd5, 32'h1, "pulse0_busy");
    tick();
    exp_out(8'h80, "pulse0_end");
    exp_rd(3'd5, 32'h0, "pulse0_idle");
    tick();

    wr(3'd4, 32'h3);
    wr(3'd3, 32'h04);
    drive_wr(3'd3, 32'h08);
    exp_out(8'h84, "ovr_c0");
    tick();
    idle();
    exp_out(8'h84, "ovr_ignored");
    exp_rd(3'd5, 32'h3, "status_ovr");
    tick();
    drive_wr(3'd0, 32'hFF);
    exp_out(8'h84, "term_pre");
    exp_rd(3'd0, 32'h84, "term_rd");
    tick();
    idle();
    exp_out(8'hFB, "term_data");
    exp_rd(3'd5, 32'h2, "ovr_sticky");
    tick();
    wr(3'd5, 32'h0);
    exp_rd(3'd5, 32'h0, "ovr_clr");
    tick();

    wr(3'd0, 32'h00);
    wr(3'd4, 32'h4);
    wr(3'd3, 32'h04);
    exp_out(8'h04, "pre_reset_hi");
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_out(8'hA5, "midrst_out");
    exp_rd(3'd5, 32'h0, "midrst_status");
    tick();
    exp_rd(3'd4, 32'h1, "midrst_len");
    tick();
    wr(3'd3, 32'h02);
    exp_out(8'hA7, "post_rst_pulse");
    exp_rd(3'd5, 32'h1, "post_rst_busy");
    tick();
    exp_out(8'hA5, "post_rst_end");
    exp_rd(3'd5, 32'h0, "post_rst_idle");
    tick();

    wr(3'd7, 32'hFF);
    exp_out(8'hA5, "addr7_wr");
    exp_rd(3'd7, 32'h0, "addr7_rd");
    tick();

`ifdef PIO_PULSE_OUT_TSTAMP_EN
    wait_ts(8'h10);
    wr(3'd0, 32'h55);
    exp_rd(3'd6, 32'h10, "ts_10");
    tick();
    wait_ts(8'hFF);
    wr(3'd0, 32'h56);
    exp_rd(3'd6, 32'hFF, "ts_ff");
    tick();
    wr(3'd4, 32'h8);
    ts_cap = ts_m;
    wr(3'd3, 32'h01);
    wr(3'd3, 32'h02);
    exp_rd(3'd6, {24'h0, ts_cap}, "ts_ignored_pulse");
    tick();
    wait_ts(8'hFF);
    wr(3'd0, 32'h01);
    wr(3'd0, 32'h02);
    exp_rd(3'd6, 32'h0, "ts_wrap");
    tick();
`else
    ts_cap = 8'h00;
    exp_rd(3'd6, {24'h0, ts_cap}, "ts_off");
    tick();
`endif

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
